// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: one synchronous write port, two combinational read ports.
// Optional build macro REGFILE_XZR_EN turns the top entry into a hardwired zero register.
module regfile_32x64 #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic [ADDR_WIDTH-1:0] rdAddrA,
  input  logic [ADDR_WIDTH-1:0] rdAddrB,
  output logic [DATA_WIDTH-1:0] rdDataA,
  output logic [DATA_WIDTH-1:0] rdDataB
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef REGFILE_XZR_EN
  localparam bit XZR_EN = 1'b1;
`else
  localparam bit XZR_EN = 1'b0;
`endif

  // Flops rather than inferred RAM: every entry must clear on reset and both reads are combinational.
  logic [DATA_WIDTH-1:0] regVal [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gReg
      if (XZR_EN && (gi == DEPTH - 1)) begin : gZero
        assign regVal[gi] = '0;
      end else begin : gStore
        logic [DATA_WIDTH-1:0] dataReg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dataReg <= '0;
          end else if (write && (wrAddr == ADDR_WIDTH'(gi))) begin
            dataReg <= wrData;
          end
        end

        assign regVal[gi] = dataReg;
      end
    end
  endgenerate

  // No write-to-read bypass: a same-cycle write becomes visible only after the edge.
  assign rdDataA = regVal[rdAddrA];
  assign rdDataB = regVal[rdAddrB];

endmodule

// File: tb/tb_regfile_32x64.sv
// Scoreboard bench for regfile_32x64: stimulus pushes expected read results, a monitor pops and compares.
// Honours REGFILE_XZR_EN in the reference model when the design is built with it.
module tb_regfile_32x64;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [4:0]  wrAddr;
  logic [63:0] wrData;
  logic [4:0]  rdAddrA;
  logic [4:0]  rdAddrB;
  logic [63:0] rdDataA;
  logic [63:0] rdDataB;

  regfile_32x64 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .write   (write),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .rdAddrA (rdAddrA),
    .rdAddrB (rdAddrB),
    .rdDataA (rdDataA),
    .rdDataB (rdDataB)
  );

`ifdef REGFILE_XZR_EN
  localparam bit XZR_EN = 1'b1;
`else
  localparam bit XZR_EN = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents.
  logic [63:0] mem [32];

  typedef struct {
    string       tag;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [63:0] expA;
    logic [63:0] expB;
  } txn_t;

  txn_t txnQ[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [63:0] modelRead(input logic [4:0] addr);
    if (XZR_EN && addr == 5'd31) return 64'h0;
    return mem[addr];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mem[i] = 64'h0;
  endtask

  task automatic modelWrite(input logic [4:0] addr, input logic [63:0] data);
    if (!(XZR_EN && addr == 5'd31)) mem[addr] = data;
  endtask

  // Issue one read transaction and hold the addresses until the monitor has checked it.
  task automatic doRead(input logic [4:0] a, input logic [4:0] b, input string tag);
    txn_t t;
    rdAddrA = a;
    rdAddrB = b;
    t.tag  = tag;
    t.a    = a;
    t.b    = b;
    t.expA = modelRead(a);
    t.expB = modelRead(b);
    txnQ.push_back(t);
    wait (txnQ.size() == 0);
  endtask

  // One write-port cycle; en=0 drives address/data with the enable low.
  task automatic doWrite(input logic [4:0] a, input logic [63:0] d, input bit en);
    @(negedge clk);
    write  = en;
    wrAddr = a;
    wrData = d;
    @(posedge clk);
    if (en) modelWrite(a, d);
    #1;
    write = 1'b0;
    $display("WR  en=%0d addr=%0d data=%h", en, a, d);
  endtask

  // Monitor: the read ports are combinational, so sample 1 time unit after the addresses settle.
  initial begin
    txn_t t;
    forever begin
      wait (txnQ.size() != 0);
      #1;
      t = txnQ[0];
      checks++;
      if (rdDataA !== t.expA)
        $display("FAIL %s portA addr=%0d got=%h exp=%h", t.tag, t.a, rdDataA, t.expA);
      else
        passes++;
      checks++;
      if (rdDataB !== t.expB)
        $display("FAIL %s portB addr=%0d got=%h exp=%h", t.tag, t.b, rdDataB, t.expB);
      else
        passes++;
      $display("RD  %s A[%0d]=%h B[%0d]=%h", t.tag, t.a, rdDataA, t.b, rdDataB);
      void'(txnQ.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ra, rb, wa;
    logic [63:0] wd;

    rst_n   = 1'b0;
    write   = 1'b0;
    wrAddr  = 5'd0;
    wrData  = 64'h0;
    rdAddrA = 5'd0;
    rdAddrB = 5'd0;
    modelReset();

    // Reads during initial reset.
    #12;
    doRead(5'd0, 5'd31, "rst_hold");
    doRead(5'd8, 5'd15, "rst_hold");
    #8;
    rst_n = 1'b1;

    // First edge after deassertion must take the write.
    doWrite(5'd3, 64'h0123_4567_89AB_CDEF, 1'b1);
    doRead(5'd3, 5'd3, "first_wr");

    // Directed write/readback.
    doWrite(5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    doWrite(5'd8,  64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    doWrite(5'd15, 64'hCCCC_CCCC_CCCC_CCCC, 1'b1);
    doWrite(5'd31, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1);
    doRead(5'd0, 5'd8, "wr_rb");
    doRead(5'd15, 5'd31, "wr_rb");

    // Write disabled for three edges.
    for (int i = 0; i < 3; i++) doWrite(5'd8, 64'h1234, 1'b0);
    doRead(5'd8, 5'd8, "wr_dis");

    // Read-during-write on the same address.
    @(negedge clk);
    write  = 1'b1;
    wrAddr = 5'd15;
    wrData = 64'h5555_5555_5555_5555;
    doRead(5'd15, 5'd15, "rdw_pre");
    @(posedge clk);
    modelWrite(5'd15, 64'h5555_5555_5555_5555);
    #1;
    write = 1'b0;
    doRead(5'd15, 5'd15, "rdw_post");

    // Address change between edges.
    @(negedge clk);
    doRead(5'd0, 5'd15, "async");
    doRead(5'd8, 5'd15, "async");

    // Mid-simulation reset pulse, then sweep every address on both ports.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    modelReset();
    for (int i = 0; i < 32; i++) doRead(5'(i), 5'(31 - i), "rst_sweep");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset coincident with a write edge.
    doWrite(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    @(negedge clk);
    write  = 1'b1;
    wrAddr = 5'd0;
    wrData = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    rst_n = 1'b0;
    modelReset();
    #1;
    write = 1'b0;
    doRead(5'd0, 5'd0, "rst_vs_wr");
    @(negedge clk);
    rst_n = 1'b1;
    doWrite(5'd0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    doRead(5'd0, 5'd31, "post_rst_wr");

    // Randomised mix of writes (enabled or not) and reads.
    for (int i = 0; i < 200; i++) begin
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0, 1: doWrite(wa, wd, 1'b1);
        2:    doWrite(wa, wd, 1'b0);
        default: ;
      endcase
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      doRead(ra, rb, "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
